// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// Optional statistics are enabled by defining FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DROP_CNT_W = 8;
  localparam int ACC_CNT_W  = 16;
  localparam int BURST_CNT_W = 4;

  // Index width for n producers; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or above rr_ptr,
// wrapping around, reported as one-hot grant plus binary index.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = id_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  logic [IDX_W-1:0] cand [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = wrap_add(rr_ptr, gi);
    end
  endgenerate

  // Scan from the farthest candidate back so the closest one wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        idx = cand[k];
        any = 1'b1;
      end
    end
    grant = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port; checks acks.
// Define FIFO_ARB_STATS_EN to add per-producer accept counters (acc_cnt).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic [id_width(NUM_REQ)-1:0]  grant_id,
  output logic                          err_drop,
  output logic [DROP_CNT_W-1:0]         drop_cnt
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*ACC_CNT_W-1:0]  acc_cnt
`endif
);

  localparam int ID_W = id_width(NUM_REQ);
  localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(BURST_LEN);

  arb_state_e               state_q, state_d;
  logic [ID_W-1:0]          owner_q, owner_d;
  logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [BURST_CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic                     wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0]    data_q, data_d;
  logic [ID_W-1:0]          grant_id_q, grant_id_d;
  logic                     ack_pend_q, ack_pend_d;
  logic                     err_drop_q, err_drop_d;
  logic [DROP_CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

  logic                     can_issue;
  logic                     accept;
  logic [ID_W-1:0]          accept_idx;
  logic                     drop;
  logic [NUM_REQ-1:0]       pick_grant;
  logic [ID_W-1:0]          pick_idx;
  logic                     pick_any;
  logic [FIFO_WIDTH-1:0]    req_word [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
    end
  endgenerate

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // A write already in flight while almost full will fill the FIFO.
  assign can_issue = !fifo_full && !(fifo_almostfull && wr_en_q);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    req_ready   = '0;
    accept      = 1'b0;
    accept_idx  = '0;
    case (state_q)
      IDLE: begin
        if (can_issue && pick_any) begin
          req_ready   = pick_grant;
          accept      = 1'b1;
          accept_idx  = pick_idx;
          owner_d     = pick_idx;
          burst_cnt_d = BURST_CNT_W'(1);
          if (BURST_LEN == 1) rr_ptr_d = next_id(pick_idx);
          else                state_d  = BURST;
        end
      end
      BURST: begin
        if (!req_valid[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = next_id(owner_q);
        end else if (can_issue) begin
          req_ready[owner_q] = 1'b1;
          accept      = 1'b1;
          accept_idx  = owner_q;
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_d == BURST_MAX) begin
            state_d  = IDLE;
            rr_ptr_d = next_id(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) req_ready = '0;
  end

  always_comb begin
    wr_en_d    = accept;
    data_d     = accept ? req_word[accept_idx] : data_q;
    grant_id_d = accept ? accept_idx : grant_id_q;
    ack_pend_d = wr_en_q;
    drop       = ack_pend_q && (!fifo_wr_ack || fifo_overflow);
    err_drop_d = err_drop_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != {DROP_CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      wr_en_q     <= 1'b0;
      data_q      <= '0;
      grant_id_q  <= '0;
      ack_pend_q  <= 1'b0;
      err_drop_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      wr_en_q     <= wr_en_d;
      data_q      <= data_d;
      grant_id_q  <= grant_id_d;
      ack_pend_q  <= ack_pend_d;
      err_drop_q  <= err_drop_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign grant_id     = grant_id_q;
  assign err_drop     = err_drop_q;
  assign drop_cnt     = drop_cnt_q;

`ifdef FIFO_ARB_STATS_EN
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_acc
      logic [ACC_CNT_W-1:0] acc_q, acc_d;

      always_comb begin
        acc_d = acc_q;
        if (req_valid[gi] && req_ready[gi] && acc_q != {ACC_CNT_W{1'b1}}) acc_d = acc_q + 1'b1;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
      end

      assign acc_cnt[gi*ACC_CNT_W +: ACC_CNT_W] = acc_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed phases plus a random run
// against a queue-based producer/FIFO environment and a behavioural model.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int BL    = 4;
  localparam int DEPTH = 8;
  localparam int IW    = id_width(N);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_wr_en;
  logic [W-1:0]    fifo_data_in;
  logic            fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
  logic [IW-1:0]   grant_id;
  logic            err_drop;
  logic [7:0]      drop_cnt;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] acc_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .BURST_LEN(BL)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_data_in    (fifo_data_in),
    .fifo_full       (fifo_full),
    .fifo_almostfull (fifo_almostfull),
    .fifo_wr_ack     (fifo_wr_ack),
    .fifo_overflow   (fifo_overflow),
    .grant_id        (grant_id),
    .err_drop        (err_drop),
    .drop_cnt        (drop_cnt)
`ifdef FIFO_ARB_STATS_EN
    ,
    .acc_cnt         (acc_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // producer word queues; a producer is valid whenever its queue is non-empty
  logic [W-1:0] src_q [N][$];
  // FIFO environment
  int   f_cnt;
  logic f_ack, f_ovf;
  int   rd_mode;
  bit   force_drop;
  int   wr_seen, ovf_seen, cyc;
  int   gid_log[$];
  logic [W-1:0] data_log[$];
  int   wcyc_log[$];
  // behavioural reference
  int   m_owner, m_run, m_ptr, m_id, m_drops;
  logic m_wr_en, m_pend, m_err;
  logic [W-1:0] m_data;
  int   m_acc [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick();
    int idx;
    if (fifo_full || (fifo_almostfull && m_wr_en)) return -1;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (req_valid[idx]) return idx;
      end
      return -1;
    end
    return req_valid[m_owner] ? m_owner : -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (src_q[i].size() > 0);
      req_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
    fifo_full       = (f_cnt >= DEPTH);
    fifo_almostfull = (f_cnt >= DEPTH - 1);
    fifo_wr_ack     = f_ack;
    fifo_overflow   = f_ovf;
  endtask

  task automatic cycle();
    int a, pre;
    logic dut_wr, ack_in;
    bit rd;
    drive_inputs();
    #1;
    a = model_pick();
    check("req_ready", 64'(req_ready), (a >= 0) ? (64'd1 << a) : 64'd0);
    check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
    dut_wr = fifo_wr_en;
    ack_in = fifo_wr_ack;
    rd = (rd_mode == 1) || (rd_mode == 2 && $urandom_range(0, 1) == 1);
    @(posedge clk);
    // FIFO reacts to the write present on its port during the cycle just ended
    pre = f_cnt;
    f_ack = 1'b0;
    f_ovf = 1'b0;
    if (dut_wr) begin
      wr_seen++;
      if (pre >= DEPTH) begin
        f_ovf = 1'b1;
        ovf_seen++;
      end else if (force_drop) begin
        f_ovf = 1'b1;
        force_drop = 1'b0;
      end else begin
        f_ack = 1'b1;
        f_cnt++;
      end
    end
    if (rd && pre > 0) f_cnt--;
    // reference model: ack check, then write register and arbitration
    if (m_pend && !ack_in) begin
      m_err = 1'b1;
      if (m_drops < 255) m_drops++;
    end
    m_pend = m_wr_en;
    if (a >= 0) begin
      m_wr_en = 1'b1;
      m_data  = src_q[a][0];
      m_id    = a;
      if (m_acc[a] < 65535) m_acc[a]++;
      if (m_owner < 0) begin
        m_owner = a;
        m_run   = 1;
      end else begin
        m_run++;
      end
      if (m_run == BL) begin
        m_ptr   = (a + 1) % N;
        m_owner = -1;
      end
      void'(src_q[a].pop_front());
    end else begin
      m_wr_en = 1'b0;
      if (m_owner >= 0 && !req_valid[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    #1;
    check("wr_en", 64'(fifo_wr_en), 64'(m_wr_en));
    check("data_in", 64'(fifo_data_in), 64'(m_data));
    check("grant_id", 64'(grant_id), 64'(m_id));
    check("err_drop", 64'(err_drop), 64'(m_err));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
    if (fifo_wr_en) begin
      gid_log.push_back(int'(grant_id));
      data_log.push_back(fifo_data_in);
      wcyc_log.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    req_valid = '1;
    req_data  = '1;
    fifo_full = 1'b0;
    fifo_almostfull = 1'b0;
    #1;
    check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    check("rst_data", 64'(fifo_data_in), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_err", 64'(err_drop), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    m_owner = -1; m_run = 0; m_ptr = 0; m_id = 0; m_drops = 0;
    m_wr_en = 1'b0; m_pend = 1'b0; m_err = 1'b0; m_data = '0;
    for (int i = 0; i < N; i++) m_acc[i] = 0;
    f_cnt = 0; f_ack = 1'b0; f_ovf = 1'b0; force_drop = 1'b0;
    fifo_wr_ack = 1'b0;
    fifo_overflow = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_ready", 64'(req_ready), 64'd0);
    check("rst_hold_wr_en", 64'(fifo_wr_en), 64'd0);
    rst = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    int base;
    logic [W-1:0] aw [3];
    req_valid = '0; req_data = '0;
    fifo_full = 1'b0; fifo_almostfull = 1'b0; fifo_wr_ack = 1'b0; fifo_overflow = 1'b0;
    rd_mode = 0; wr_seen = 0; ovf_seen = 0; cyc = 0;
    #1;
    do_reset();

    // single producer, three words
    aw[0] = 16'hA001; aw[1] = 16'hA002; aw[2] = 16'hA003;
    for (int i = 0; i < 3; i++) src_q[0].push_back(aw[i]);
    gid_log.delete(); data_log.delete(); wcyc_log.delete();
    for (int c = 0; c < 6; c++) cycle();
    check("single_wr_count", 64'(data_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < data_log.size(); i++) begin
      check("single_data", 64'(data_log[i]), 64'(aw[i]));
      check("single_gid", 64'(gid_log[i]), 64'd0);
    end
    if (wcyc_log.size() == 3) check("single_back_to_back", 64'(wcyc_log[2] - wcyc_log[0]), 64'd2);
    check("single_err", 64'(err_drop), 64'd0);

    // all producers valid, FIFO drained every cycle: fair bursts
    do_reset();
    rd_mode = 1;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 6; k++) src_q[i].push_back(16'(i * 256 + k));
    gid_log.delete();
    for (int c = 0; c < 20; c++) cycle();
    check("fair_wr_count", 64'(gid_log.size() >= 16), 64'd1);
    for (int i = 0; i < 16 && i < gid_log.size(); i++)
      check("fair_gid_seq", 64'(gid_log[i]), 64'((i / BL) % N));

    // fill an 8-deep FIFO with no reads
    do_reset();
    rd_mode = 0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) src_q[i].push_back(16'($urandom()));
    wr_seen = 0; ovf_seen = 0;
    for (int c = 0; c < 20; c++) cycle();
    check("fill_writes", 64'(wr_seen), 64'd8);
    check("fill_overflow", 64'(ovf_seen), 64'd0);
    check("fill_level", 64'(f_cnt), 64'd8);
    check("fill_drop_cnt", 64'(drop_cnt), 64'd0);

    // one lost write: sticky flag, count of one, writes keep flowing
    rd_mode = 1;
    force_drop = 1'b1;
    for (int k = 0; k < 4; k++) src_q[1].push_back(16'($urandom()));
    base = wr_seen;
    for (int c = 0; c < 14; c++) cycle();
    check("drop_err", 64'(err_drop), 64'd1);
    check("drop_cnt_one", 64'(drop_cnt), 64'd1);
    check("drop_writes_continue", 64'((wr_seen - base) >= 2), 64'd1);

    // reset in the middle of producer 2's burst
    do_reset();
    for (int k = 0; k < 6; k++) src_q[2].push_back(16'($urandom()));
    cycle();
    cycle();
    check("mid_burst_gid", 64'(grant_id), 64'd2);
    check("mid_burst_wr", 64'(fifo_wr_en), 64'd1);
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) src_q[i].push_back(16'($urandom()));
    drive_inputs();
    #1;
    check("post_rst_first_grant", 64'(req_ready), 64'd1);
    check("post_rst_no_stale_wr", 64'(fifo_wr_en), 64'd0);
    for (int c = 0; c < 8; c++) cycle();

    // accept statistics: five from producer 1, two from producer 3
    do_reset();
    rd_mode = 1;
    for (int k = 0; k < 5; k++) src_q[1].push_back(16'($urandom()));
    for (int k = 0; k < 2; k++) src_q[3].push_back(16'($urandom()));
    for (int c = 0; c < 15; c++) cycle();
`ifdef FIFO_ARB_STATS_EN
    check("acc0", 64'(acc_cnt[0*16 +: 16]), 64'd0);
    check("acc1", 64'(acc_cnt[1*16 +: 16]), 64'd5);
    check("acc2", 64'(acc_cnt[2*16 +: 16]), 64'd0);
    check("acc3", 64'(acc_cnt[3*16 +: 16]), 64'd2);
`endif
    check("stats_phase_err", 64'(err_drop), 64'd0);

    // random traffic, random reads, occasional lost write
    rd_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (src_q[i].size() < 3 && $urandom_range(0, 2) == 0) src_q[i].push_back(16'($urandom()));
      if ($urandom_range(0, 99) == 0) force_drop = 1'b1;
      cycle();
    end
    check("random_overflow", 64'(ovf_seen), 64'd0);
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("random_acc", 64'(acc_cnt[i*16 +: 16]), 64'(m_acc[i]));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
